// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - register file read/writeback/reserve bus
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ-1:0]            rd_busy;
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           rsv_en;
    logic [ADDR_WIDTH-1:0]          rsv_addr;
    logic [ADDR_WIDTH:0]            pending_count;

    // Decode/issue/writeback side drives addresses and strobes.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, pending_count
    );

    // Register file side answers reads and tracks pending writes.
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, pending_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with bypass and pending-write scoreboard
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pendingNext;
    logic [ADDR_WIDTH:0]   pendingCount;
    logic [ADDR_WIDTH:0]   popNext;
    logic                  wrTake;
    logic                  rsvTake;
    logic [NUM_READ*DATA_WIDTH-1:0] rdData;
    logic [NUM_READ-1:0]            rdBusy;

    // Register 0 swallows writes and reservations when it is hardwired.
    assign wrTake  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsvTake = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    // Next pending vector: writeback clears, then reserve sets so a same-address
    // reserve (younger instruction) leaves the register pending.
    always_comb begin
        pendingNext = pending;
        if (wrTake) begin
            pendingNext[bus.wr_addr] = 1'b0;
        end
        if (rsvTake) begin
            pendingNext[bus.rsv_addr] = 1'b1;
        end
    end

    // Population count of the next pending vector, registered alongside it.
    always_comb begin
        popNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            popNext = popNext + {{ADDR_WIDTH{1'b0}}, pendingNext[i]};
        end
    end

    // Data storage; reset clears every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrTake) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard bits and their count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= '0;
            pendingCount <= '0;
        end else begin
            pending      <= pendingNext;
            pendingCount <= popNext;
        end
    end

    // Combinational read ports: zero register, then writeback bypass, then storage.
    // Reset forces zeros so a bypassed writeback cannot leak while rst is high.
    always_comb begin
        logic [ADDR_WIDTH-1:0] addr;
        rdData = '0;
        rdBusy = '0;
        addr   = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            addr = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (rst) begin
                rdData[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rdBusy[p]                          = 1'b0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                rdData[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rdBusy[p]                          = 1'b0;
            end else if (bus.wr_en && (bus.wr_addr == addr)) begin
                rdData[p*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
                rdBusy[p]                          = 1'b0;
            end else begin
                rdData[p*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
                rdBusy[p]                          = pending[addr];
            end
        end
    end

    assign bus.rd_data       = rdData;
    assign bus.rd_busy       = rdBusy;
    assign bus.pending_count = pendingCount;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized and directed bench for regfile_scoreboard
module tb_regfile_scoreboard;
    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) busA ();
    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) busB ();

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1)) dutA (
        .clk(clk), .rst(rst), .bus(busA)
    );
    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0)) dutB (
        .clk(clk), .rst(rst), .bus(busB)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 has a hardwired zero register, index 1 does not.
    logic [31:0] mRegs [2][32];
    bit          mPend [2][32];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) begin
                mRegs[k][a] = 32'h0;
                mPend[k][a] = 1'b0;
            end
    endfunction

    function automatic void model_edge(int k, bit we, int wa, logic [31:0] wd, bit re, int ra);
        if (we && !(k == 0 && wa == 0)) begin
            mRegs[k][wa] = wd;
            mPend[k][wa] = 1'b0;
        end
        if (re && !(k == 0 && ra == 0))
            mPend[k][ra] = 1'b1;
    endfunction

    function automatic int model_count(int k);
        int n = 0;
        for (int a = 0; a < 32; a++) n += int'(mPend[k][a]);
        return n;
    endfunction

    function automatic logic [31:0] exp_data(int k, int a, bit we, int wa, logic [31:0] wd);
        if (rst) return 32'h0;
        if (k == 0 && a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return mRegs[k][a];
    endfunction

    function automatic bit exp_busy(int k, int a, bit we, int wa);
        if (rst) return 1'b0;
        if (k == 0 && a == 0) return 1'b0;
        if (we && wa == a) return 1'b0;
        return mPend[k][a];
    endfunction

    task automatic drive(int k, bit we, int wa, logic [31:0] wd, bit re, int ra, int a0, int a1);
        if (k == 0) begin
            busA.wr_en = we; busA.wr_addr = wa[4:0]; busA.wr_data = wd;
            busA.rsv_en = re; busA.rsv_addr = ra[4:0]; busA.rd_addr = {a1[4:0], a0[4:0]};
        end else begin
            busB.wr_en = we; busB.wr_addr = wa[4:0]; busB.wr_data = wd;
            busB.rsv_en = re; busB.rsv_addr = ra[4:0]; busB.rd_addr = {a1[4:0], a0[4:0]};
        end
    endtask

    task automatic set_rst(bit v);
        rst = v;
        if (v) model_reset();
    endtask

    // Advance one edge, updating the model with the inputs sampled at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0, busA.wr_en, int'(busA.wr_addr), busA.wr_data, busA.rsv_en, int'(busA.rsv_addr));
            model_edge(1, busB.wr_en, int'(busB.wr_addr), busB.wr_data, busB.rsv_en, int'(busB.rsv_addr));
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        drive(1, 0, 0, 0, 0, 0, 7, 0);
        #2;
        testsRun++;
        if (busA.rd_data !== 64'h0 || busA.rd_busy !== 2'b00 || busA.pending_count !== 6'd0) begin
            testsFailed++;
            $display("FAIL reset_initial got data=%h busy=%b cnt=%0d want 0/00/0", busA.rd_data, busA.rd_busy, busA.pending_count);
        end
        @(posedge clk); #1;
        set_rst(0);
        drive(0, 1, 7, 32'hDEADBEEF, 1, 12, 7, 12);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("FAIL reset_bypass_r7 got %h want deadbeef", busA.rd_data[31:0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 7, 12);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'hDEADBEEF || busA.rd_busy[1] !== 1'b1 || busA.pending_count !== 6'd1) begin
            testsFailed++;
            $display("FAIL reset_stored_r7 got data=%h busy12=%b cnt=%0d want deadbeef/1/1", busA.rd_data[31:0], busA.rd_busy[1], busA.pending_count);
        end
        set_rst(1);
        #1;
        testsRun++;
        if (busA.rd_data !== 64'h0 || busA.rd_busy !== 2'b00 || busA.pending_count !== 6'd0) begin
            testsFailed++;
            $display("FAIL reset_async got data=%h busy=%b cnt=%0d want 0/00/0", busA.rd_data, busA.rd_busy, busA.pending_count);
        end
        drive(0, 1, 7, 32'h11, 1, 7, 7, 12);
        #1;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'h0) begin
            testsFailed++;
            $display("FAIL reset_no_bypass got %h want 0", busA.rd_data[31:0]);
        end
        tick();
        set_rst(0);
        drive(0, 0, 0, 0, 0, 0, 7, 12);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'h0 || busA.rd_busy !== 2'b00 || busA.pending_count !== 6'd0) begin
            testsFailed++;
            $display("FAIL reset_strobes_ignored got data=%h busy=%b cnt=%0d want 0/00/0", busA.rd_data[31:0], busA.rd_busy, busA.pending_count);
        end
    endtask

    task automatic test_write_read();
        drive(0, 1, 3, 32'h12345678, 0, 0, 3, 3);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'h12345678 || busA.rd_busy[0] !== 1'b0) begin
            testsFailed++;
            $display("FAIL wr_bypass got %h busy=%b want 12345678/0", busA.rd_data[31:0], busA.rd_busy[0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 3, 3);
        #2;
        testsRun++;
        if (busA.rd_data !== {32'h12345678, 32'h12345678}) begin
            testsFailed++;
            $display("FAIL wr_stored got %h want 1234567812345678", busA.rd_data);
        end
    endtask

    task automatic test_zero_reg();
        drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        drive(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'h0 || busA.rd_busy[0] !== 1'b0) begin
            testsFailed++;
            $display("FAIL zero_bypass got %h busy=%b want 0/0", busA.rd_data[31:0], busA.rd_busy[0]);
        end
        testsRun++;
        if (busB.rd_data[31:0] !== 32'hFFFFFFFF) begin
            testsFailed++;
            $display("FAIL nozero_bypass got %h want ffffffff", busB.rd_data[31:0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'h0 || busA.rd_busy[0] !== 1'b0 || busA.pending_count !== 6'd0) begin
            testsFailed++;
            $display("FAIL zero_after got data=%h busy=%b cnt=%0d want 0/0/0", busA.rd_data[31:0], busA.rd_busy[0], busA.pending_count);
        end
        testsRun++;
        if (busB.rd_data[31:0] !== 32'hFFFFFFFF || busB.rd_busy[0] !== 1'b1 || busB.pending_count !== 6'd1) begin
            testsFailed++;
            $display("FAIL nozero_after got data=%h busy=%b cnt=%0d want ffffffff/1/1", busB.rd_data[31:0], busB.rd_busy[0], busB.pending_count);
        end
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 0, 0, 1, 5, 5, 5);
        #2;
        testsRun++;
        if (busA.rd_busy !== 2'b00) begin
            testsFailed++;
            $display("FAIL sb_same_cycle got busy=%b want 00", busA.rd_busy);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 5, 5);
        #2;
        testsRun++;
        if (busA.rd_busy !== 2'b11 || busA.pending_count !== 6'd1) begin
            testsFailed++;
            $display("FAIL sb_reserved got busy=%b cnt=%0d want 11/1", busA.rd_busy, busA.pending_count);
        end
        drive(0, 1, 5, 32'hA5A5A5A5, 0, 0, 5, 5);
        #2;
        testsRun++;
        if (busA.rd_busy !== 2'b00 || busA.rd_data[31:0] !== 32'hA5A5A5A5) begin
            testsFailed++;
            $display("FAIL sb_writeback got busy=%b data=%h want 00/a5a5a5a5", busA.rd_busy, busA.rd_data[31:0]);
        end
        tick();
        testsRun++;
        if (busA.pending_count !== 6'd0) begin
            testsFailed++;
            $display("FAIL sb_released got cnt=%0d want 0", busA.pending_count);
        end
    endtask

    task automatic test_simultaneous();
        drive(0, 0, 0, 0, 1, 9, 9, 9);
        tick();
        drive(0, 1, 9, 32'h0BADF00D, 1, 9, 9, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 9, 9);
        #2;
        testsRun++;
        if (busA.rd_data[31:0] !== 32'h0BADF00D || busA.rd_busy[0] !== 1'b1 || busA.pending_count !== 6'd1) begin
            testsFailed++;
            $display("FAIL same_addr got data=%h busy=%b cnt=%0d want 0badf00d/1/1", busA.rd_data[31:0], busA.rd_busy[0], busA.pending_count);
        end
        drive(0, 0, 0, 0, 1, 4, 2, 4);
        tick();
        drive(0, 1, 4, 32'h44, 1, 2, 2, 4);
        tick();
        drive(0, 0, 0, 0, 0, 0, 2, 4);
        #2;
        testsRun++;
        if (busA.rd_busy !== 2'b01 || busA.rd_data[63:32] !== 32'h44 || busA.pending_count !== 6'd2) begin
            testsFailed++;
            $display("FAIL diff_addr got busy=%b r4=%h cnt=%0d want 01/44/2", busA.rd_busy, busA.rd_data[63:32], busA.pending_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                bit we = 1'($urandom_range(0, 1));
                bit re = 1'($urandom_range(0, 1));
                int wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
                int ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
                int a0 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
                int a1 = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 31));
                drive(k, we, wa, $urandom, re, ra, a0, a1);
            end
            #2;
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    int          a   = (k == 0) ? int'(busA.rd_addr[p*5 +: 5]) : int'(busB.rd_addr[p*5 +: 5]);
                    bit          we  = (k == 0) ? busA.wr_en : busB.wr_en;
                    int          wa  = (k == 0) ? int'(busA.wr_addr) : int'(busB.wr_addr);
                    logic [31:0] wd  = (k == 0) ? busA.wr_data : busB.wr_data;
                    logic [31:0] gd  = (k == 0) ? busA.rd_data[p*32 +: 32] : busB.rd_data[p*32 +: 32];
                    logic        gb  = (k == 0) ? busA.rd_busy[p] : busB.rd_busy[p];
                    logic [31:0] ed  = exp_data(k, a, we, wa, wd);
                    bit          eb  = exp_busy(k, a, we, wa);
                    testsRun++;
                    if (gd !== ed || gb !== eb) begin
                        testsFailed++;
                        $display("FAIL rand_read inst=%0d port=%0d addr=%0d got %h/%b want %h/%b", k, p, a, gd, gb, ed, eb);
                    end
                end
            end
            tick();
            testsRun++;
            if (int'(busA.pending_count) != model_count(0) || int'(busB.pending_count) != model_count(1)) begin
                testsFailed++;
                $display("FAIL rand_count got %0d/%0d want %0d/%0d", busA.pending_count, busB.pending_count, model_count(0), model_count(1));
            end
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_and_reset();
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 1, a, 1, 31);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 31);
        #2;
        testsRun++;
        if (busA.pending_count !== 6'd31 || busA.rd_busy !== 2'b11) begin
            testsFailed++;
            $display("FAIL full_count got cnt=%0d busy=%b want 31/11", busA.pending_count, busA.rd_busy);
        end
        drive(0, 0, 0, 0, 1, 5, 1, 31);
        set_rst(1);
        #1;
        testsRun++;
        if (busA.pending_count !== 6'd0) begin
            testsFailed++;
            $display("FAIL full_reset_count got %0d want 0", busA.pending_count);
        end
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 1, 5, a, a + 16);
            #0.1;
            testsRun++;
            if (busA.rd_busy !== 2'b00) begin
                testsFailed++;
                $display("FAIL full_reset_busy addr=%0d got %b want 00", a, busA.rd_busy);
            end
        end
        tick();
        set_rst(0);
        drive(0, 0, 0, 0, 0, 0, 5, 9);
        #2;
        testsRun++;
        if (busA.pending_count !== 6'd0 || busA.rd_busy !== 2'b00) begin
            testsFailed++;
            $display("FAIL full_after_reset got cnt=%0d busy=%b want 0/00", busA.pending_count, busA.rd_busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clk = 1'b0;
        set_rst(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_random();
        test_full_and_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
